// File: rtl/uplink_capture_pkg.sv
// uplink_capture_pkg: shared frame width, counter width and capture state encoding
package uplink_capture_pkg;
  localparam int FRAME_W = 234;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
endpackage

// File: rtl/uplink_trig_match.sv
// uplink_trig_match: masked frame/pattern compare OR software trigger, qualified by frame valid
module uplink_trig_match #(
  parameter int W = uplink_capture_pkg::FRAME_W
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] pattern,
  input  logic [W-1:0] mask,
  input  logic         rdy,
  input  logic         sw_trig,
  input  logic         match_en,
  output logic         hit
);
  assign hit = rdy & (sw_trig | (match_en & ~|((data ^ pattern) & mask)));
endmodule

// File: rtl/uplink_frame_capture.sv
// uplink_frame_capture: armed, triggered capture of uplink frames into the dataframe FIFO
// UPLINK_CAPTURE_FEC_DROP_EN drops and counts frames flagged with an FEC error
module uplink_frame_capture #(
  parameter int FRAME_W = uplink_capture_pkg::FRAME_W,
  parameter int CNT_W = uplink_capture_pkg::CNT_W
) (
  input  logic               clk40_i,
  input  logic               rst_i,
  input  logic [FRAME_W-1:0] uplinkUserData_i,
  input  logic               uplinkrdy_i,
  input  logic               uplinkFEC_i,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic               sw_trig_i,
  input  logic [FRAME_W-1:0] trig_pattern_i,
  input  logic [FRAME_W-1:0] trig_mask_i,
  input  logic [CNT_W-1:0]   capture_len_i,
  input  logic               fifo_full_i,
  output logic [FRAME_W-1:0] frame_o,
  output logic               frame_wr_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   captured_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o,
  output logic [CNT_W-1:0]   fec_drop_cnt_o
);
  import uplink_capture_pkg::*;
  state_t state;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic hit, fec_bad, consume, wr, last, can_arm;
`ifdef UPLINK_CAPTURE_FEC_DROP_EN
  assign fec_bad = uplinkFEC_i;
`else
  logic unused_fec;
  assign unused_fec = uplinkFEC_i;
  assign fec_bad = 1'b0;
`endif
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + CNT_W'(1);
  endfunction
  uplink_trig_match #(.W(FRAME_W)) u_match (
    .data(uplinkUserData_i),
    .pattern(trig_pattern_i),
    .mask(trig_mask_i),
    .rdy(uplinkrdy_i),
    .sw_trig(sw_trig_i),
    .match_en(!fec_bad),
    .hit(hit)
  );
  // the trigger frame itself is consumed, so ARMED consumes on the hit cycle
  assign consume = uplinkrdy_i & !abort_i & (state == CAPTURE | (state == ARMED & hit));
  assign wr = consume & !fifo_full_i & !fec_bad;
  assign idx_nxt = idx + CNT_W'(1);
  assign last = (capture_len_i != '0) && (idx_nxt == capture_len_i);
  assign can_arm = arm_i & (state == IDLE | state == DONE);
  assign busy_o = (state == ARMED) | (state == CAPTURE);
  assign done_o = state == DONE;
  always_ff @(posedge clk40_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      captured_cnt_o <= '0;
      drop_cnt_o <= '0;
      fec_drop_cnt_o <= '0;
      frame_o <= '0;
      frame_wr_o <= 1'b0;
    end else begin
      frame_wr_o <= wr;
      if (wr) frame_o <= uplinkUserData_i;
      if (abort_i) state <= IDLE;
      else if (can_arm) begin
        state <= ARMED;
        idx <= '0;
        captured_cnt_o <= '0;
        drop_cnt_o <= '0;
        fec_drop_cnt_o <= '0;
      end else if (consume) begin
        idx <= idx_nxt;
        state <= last ? DONE : CAPTURE;
        if (fec_bad) fec_drop_cnt_o <= sat_inc(fec_drop_cnt_o);
        else if (fifo_full_i) drop_cnt_o <= sat_inc(drop_cnt_o);
        else captured_cnt_o <= sat_inc(captured_cnt_o);
      end
    end
  end
endmodule
